alu_share_arbiter: RTL and testbench

- Shares the single combinational RV32I ALU between two requesters: requester 0 is execute-stage integer ops, requester 1 is the branch/address helper.
- Arbitrates with round-robin priority and drives the ALU operand and opcode lines from registers.
- Captures the ALU result and returns it to the winning requester over a valid/ready response channel.
- Sits between the decode/execute control and the ALU instance. It contains no arithmetic of its own.

---
 rtl/alu_share_arbiter_if.sv | 28 ++
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the shared-ALU arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (0)
// and the branch/address helper (1); operands go out registered, the result comes back on rsp.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OPW-1:0]       alu_opcode,
  input  logic [WIDTH-1:0]     alu_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             rr_ptr_r;
  logic             owner_r;
  logic             busy_r;
  logic [1:0]       rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [OPW-1:0]   alu_opcode_r;
  logic             grant_s;
  logic [1:0]       req_ready_s;

  // Grant selection: a lone requester wins outright, contention goes to rr_ptr.
  always_comb begin
    grant_s     = 1'b0;
    req_ready_s = 2'b00;
    if (bus.req_valid == 2'b11) begin
      grant_s = rr_ptr_r;
    end else if (bus.req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if ((state_r == IDLE) && (bus.req_valid != 2'b00)) begin
      req_ready_s = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  // Arbitration FSM: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 1'b0;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 2'b00;
      rsp_data_r   <= {WIDTH{1'b0}};
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      alu_opcode_r <= {OPW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid != 2'b00) begin
            alu_a_r      <= grant_s ? bus.req1_a  : bus.req0_a;
            alu_b_r      <= grant_s ? bus.req1_b  : bus.req0_b;
            alu_opcode_r <= grant_s ? bus.req1_op : bus.req0_op;
            owner_r      <= grant_s;
            rr_ptr_r     <= ~grant_s;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_r  <= alu_out;
          rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
          state_r     <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready can release the response.
          if (bus.rsp_ready[owner_r]) begin
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_opcode    = alu_opcode_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural RV32I ALU attached.
// Opcode encoding {funct7[5], funct3}; 1111 is the branch-compare "equal" helper.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_out;
  logic             busy;
  int               total;
  int               bad;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: undefined encodings return zero.
  always_comb begin
    alu_out = 32'd0;
    case (alu_opcode)
      4'b0000: alu_out = alu_a + alu_b;
      4'b1000: alu_out = alu_a - alu_b;
      4'b0001: alu_out = alu_a << alu_b[4:0];
      4'b0010: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'b0011: alu_out = {31'd0, (alu_a < alu_b)};
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b0101: alu_out = alu_a >> alu_b[4:0];
      4'b1101: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_out = alu_a | alu_b;
      4'b0111: alu_out = alu_a & alu_b;
      4'b1111: alu_out = {31'd0, (alu_a == alu_b)};
      default: alu_out = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 4'd0;
    bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 4'd0;
    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
    chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
    chk("rst_alu_op", {60'd0, alu_opcode}, 64'd0);
    rst_n = 1'b1;
    step();

    // Test 1: req0 add 5+7
    bus.req_valid = 2'b01; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_op = 4'b0000;
    #1;
    chk("t1_req_ready", {62'd0, bus.req_ready}, 64'd1);
    step();
    bus.req_valid = 2'b00;
    chk("t1_exec_busy", {63'd0, busy}, 64'd1);
    chk("t1_exec_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("t1_alu_a", {32'd0, alu_a}, 64'd5);
    chk("t1_alu_b", {32'd0, alu_b}, 64'd7);
    step();
    chk("t1_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
    chk("t1_rsp_data", {32'd0, bus.rsp_data}, 64'd12);
    // req1 shows up while the response is being consumed: must not be accepted yet
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b10; bus.req1_a = 32'd3; bus.req1_b = 32'd5; bus.req1_op = 4'b1000;
    #1;
    chk("t1_no_accept_resp", {62'd0, bus.req_ready}, 64'd0);
    step();
    bus.rsp_ready = 2'b00;
    chk("t1_done_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("t1_done_busy", {63'd0, busy}, 64'd0);

    // Test 2: req1 sub 3-5
    chk("t2_req_ready", {62'd0, bus.req_ready}, 64'd2);
    step();
    bus.req_valid = 2'b00;
    chk("t2_exec_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    step();
    chk("t2_rsp_valid", {62'd0, bus.rsp_valid}, 64'd2);
    chk("t2_rsp_data", {32'd0, bus.rsp_data}, 64'hFFFF_FFFE);
    bus.rsp_ready = 2'b01;
    step();
    chk("t2_nonowner_ignored", {62'd0, bus.rsp_valid}, 64'd2);
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;
    chk("t2_done_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("t2_done_busy", {63'd0, busy}, 64'd0);

    // Test 3: continuous contention from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req0_a = 32'd1;    bus.req0_b = 32'd1;    bus.req0_op = 4'b0000;
    bus.req1_a = 32'hF0;   bus.req1_b = 32'hFF;   bus.req1_op = 4'b0100;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_grant", {62'd0, bus.req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      step();
      step();
      chk("t3_rsp_valid", {62'd0, bus.rsp_valid}, (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t3_rsp_data", {32'd0, bus.rsp_data}, (i % 2 == 0) ? 64'd2 : 64'h0F);
      bus.rsp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      bus.rsp_ready = 2'b00;
      chk("t3_idle", {63'd0, busy}, 64'd0);
    end
    bus.req_valid = 2'b00;

    // Test 4: response backpressure, op 1111 with a=b=9
    bus.req_valid = 2'b01; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = 4'b1111;
    step();
    bus.req_valid = 2'b10; bus.req1_a = 32'd2; bus.req1_b = 32'd3; bus.req1_op = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
      chk("t4_hold_rsp_data", {32'd0, bus.rsp_data}, 64'd1);
      chk("t4_hold_alu", {alu_a, alu_b}, {32'd9, 32'd9});
      chk("t4_hold_op", {60'd0, alu_opcode}, 64'hF);
      chk("t4_hold_req_ready", {62'd0, bus.req_ready}, 64'd0);
      step();
    end
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b00;
    step();
    bus.rsp_ready = 2'b00;
    chk("t4_idle_busy", {63'd0, busy}, 64'd0);
    chk("t4_idle_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);

    // Test 5: async reset during EXEC (rr_ptr is 1 after this grant to req0)
    bus.req_valid = 2'b01; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_op = 4'b0000;
    step();
    bus.req_valid = 2'b00;
    chk("t5_in_exec", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_alu_a", {32'd0, alu_a}, 64'd0);
    chk("t5_rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    step();
    step();
    chk("t5_no_rsp", {62'd0, bus.rsp_valid}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("t5_no_rsp_after", {62'd0, bus.rsp_valid}, 64'd0);
    bus.req0_a = 32'd6; bus.req0_b = 32'd1; bus.req0_op = 4'b1000;
    bus.req1_a = 32'd1; bus.req1_b = 32'd1; bus.req1_op = 4'b0000;
    bus.req_valid = 2'b11;
    #1;
    chk("t5_rrptr_reset", {62'd0, bus.req_ready}, 64'd1);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t5_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
    chk("t5_rsp_data", {32'd0, bus.rsp_data}, 64'd5);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;

    // Test 6: undefined opcode returns zero with normal latency
    bus.req_valid = 2'b10; bus.req1_a = 32'd4; bus.req1_b = 32'd4; bus.req1_op = 4'b1010;
    #1;
    chk("t6_req_ready", {62'd0, bus.req_ready}, 64'd2);
    step();
    bus.req_valid = 2'b00;
    chk("t6_exec_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("t6_alu_op", {60'd0, alu_opcode}, 64'hA);
    step();
    chk("t6_rsp_valid", {62'd0, bus.rsp_valid}, 64'd2);
    chk("t6_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;
    chk("t6_idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
